// File: rtl/pwm_cap_pkg.sv
// Purpose: shared types and helpers for the three-channel PWM duty capture block.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package pwm_cap_pkg;

  // Width of every published duty value.
  localparam int unsigned DUTY_W = 8;

  // Largest representable duty; an all-low frame saturates to this.
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  typedef logic [DUTY_W-1:0] duty_t;

  // Scale a frame's low-cycle total down to DUTY_W bits by dropping the
  // low (frame_w - DUTY_W) bits (floor), clamping the one overflow case
  // (a frame that was low on every cycle) to DUTY_MAX.
  function automatic duty_t sat_duty(input logic [31:0] total, input int unsigned frame_w);
    logic [31:0] w_shifted;
    w_shifted = total >> (frame_w - DUTY_W);
    if (w_shifted > 32'(DUTY_MAX)) begin
      return DUTY_MAX;
    end
    return w_shifted[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_cap_channel.sv
// Purpose: one PWM channel - synchroniser, edge detect, low counter, toggle flag, duty/edge output registers.
// Latency: input to counter SYNC_STAGES cycles; outputs update on the frame_end clock edge.
// Backpressure: none; outputs hold their value until the next frame end.
module pwm_cap_channel
  import pwm_cap_pkg::*;
#(
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_n,
  input  logic              frame_end,
  output logic [DUTY_W-1:0] duty,
  output logic              edge_seen
);

  // Synchroniser chain; reset to 1 so the input reads as deasserted.
  logic [SYNC_STAGES-1:0] r_sync;
  // Previous synchronised value, used for edge detection.
  logic                   r_prev;
  // Low-cycle counter; one extra bit so an all-low frame (2^FRAME_W) fits.
  logic [FRAME_W:0]       r_low_cnt;
  // Sticky flag: at least one synchronised edge seen this frame.
  logic                   r_toggle;
  // Published results of the last completed frame.
  logic [DUTY_W-1:0]      r_duty;
  logic                   r_edge_seen;

  logic                   w_sync;
  logic                   w_act;
  logic                   w_edge;
  logic [FRAME_W:0]       w_total;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_act   = ~w_sync;
  assign w_edge  = w_sync ^ r_prev;
  // The frame-end cycle's own sample belongs to the ending frame.
  assign w_total = r_low_cnt + (FRAME_W+1)'(w_act);

  // Shift the asynchronous input through the synchroniser and track the previous synced value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_n};
      r_prev <= w_sync;
    end
  end

  // Accumulate low cycles and edges; restart both at frame end so the next sample starts the new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_low_cnt <= '0;
      r_toggle  <= 1'b0;
    end else if (frame_end) begin
      r_low_cnt <= '0;
      r_toggle  <= 1'b0;
    end else begin
      r_low_cnt <= w_total;
      r_toggle  <= r_toggle | w_edge;
    end
  end

  // Publish the completed frame's duty and edge flag; hold between frame ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty      <= '0;
      r_edge_seen <= 1'b0;
    end else if (frame_end) begin
      r_duty      <= sat_duty(32'(w_total), FRAME_W);
      r_edge_seen <= r_toggle | w_edge;
    end
  end

  assign duty      = r_duty;
  assign edge_seen = r_edge_seen;

endmodule

// File: rtl/pwm_duty_capture.sv
// Purpose: three-channel active-low PWM duty decoder publishing 8-bit duty per 2^FRAME_W clock frame.
// Latency: SYNC_STAGES cycles input to count; results and duty_valid_o appear the cycle after frame end.
// Backpressure: none; consumers sample on duty_valid_o, outputs hold between pulses.
module pwm_duty_capture
  import pwm_cap_pkg::*;
#(
  // FRAME_W must be >= 8 and match the source PWM period; SYNC_STAGES must be >= 2.
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_24MHz_i,
  input  logic                   rst_n_i,
  input  logic                   PWM_R_n_i,
  input  logic                   PWM_G_n_i,
  input  logic                   PWM_B_n_i,
  output logic [DUTY_W-1:0]      duty_R_o,
  output logic [DUTY_W-1:0]      duty_G_o,
  output logic [DUTY_W-1:0]      duty_B_o,
  output logic                   duty_valid_o,
  output logic [2:0]             edge_seen_o
);

  // Shared free-running frame counter.
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_duty_valid;
  logic               w_frame_end;
  logic               w_edge_r;
  logic               w_edge_g;
  logic               w_edge_b;

  // Last cycle of a frame is when the counter is all ones.
  assign w_frame_end = &r_frame_cnt;

  // Free-running frame counter; a reset restarts the frame and discards any partial one.
  always_ff @(posedge clk_24MHz_i) begin
    if (!rst_n_i) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
    end
  end

  // One-cycle valid pulse coinciding with the channels' output update.
  always_ff @(posedge clk_24MHz_i) begin
    if (!rst_n_i) begin
      r_duty_valid <= 1'b0;
    end else begin
      r_duty_valid <= w_frame_end;
    end
  end

  pwm_cap_channel #(
    .FRAME_W     (FRAME_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chan_r (
    .clk       (clk_24MHz_i),
    .rst_n     (rst_n_i),
    .pwm_n     (PWM_R_n_i),
    .frame_end (w_frame_end),
    .duty      (duty_R_o),
    .edge_seen (w_edge_r)
  );

  pwm_cap_channel #(
    .FRAME_W     (FRAME_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chan_g (
    .clk       (clk_24MHz_i),
    .rst_n     (rst_n_i),
    .pwm_n     (PWM_G_n_i),
    .frame_end (w_frame_end),
    .duty      (duty_G_o),
    .edge_seen (w_edge_g)
  );

  pwm_cap_channel #(
    .FRAME_W     (FRAME_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chan_b (
    .clk       (clk_24MHz_i),
    .rst_n     (rst_n_i),
    .pwm_n     (PWM_B_n_i),
    .frame_end (w_frame_end),
    .duty      (duty_B_o),
    .edge_seen (w_edge_b)
  );

  assign duty_valid_o = r_duty_valid;
  assign edge_seen_o  = {w_edge_r, w_edge_g, w_edge_b};

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Purpose: scoreboard bench for pwm_duty_capture built with a 1024-clock frame.
// Latency: expected frame results are queued by stimulus and popped on each duty_valid_o.
// Backpressure: n/a.
module tb_pwm_duty_capture;

  localparam int FW   = 10;
  localparam int FLEN = 1 << FW;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_r = 1'b1;
  logic       pwm_g = 1'b1;
  logic       pwm_b = 1'b1;
  logic [7:0] duty_r;
  logic [7:0] duty_g;
  logic [7:0] duty_b;
  logic       valid;
  logic [2:0] edge_seen;

  int cyc        = 0;  // clock edges since reset release
  int scen       = 0;  // active stimulus pattern
  int tests      = 0;
  int fails      = 0;
  int mon_frames = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [2:0] e;
    bit         chk;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_duty_capture #(
    .FRAME_W     (FW),
    .SYNC_STAGES (2)
  ) dut (
    .clk_24MHz_i  (clk),
    .rst_n_i      (rst_n),
    .PWM_R_n_i    (pwm_r),
    .PWM_G_n_i    (pwm_g),
    .PWM_B_n_i    (pwm_b),
    .duty_R_o     (duty_r),
    .duty_G_o     (duty_g),
    .duty_B_o     (duty_b),
    .duty_valid_o (valid),
    .edge_seen_o  (edge_seen)
  );

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pin level (1 = low/asserted) for channel ch ahead of clock edge number e after release.
  function automatic bit is_low(int s, int ch, int e);
    int len;
    int ph;
    case (s)
      1: return 1'b1;
      2: begin
        case (ch)
          0:       begin len = 512; ph = 137; end
          1:       begin len = 256; ph = 900; end
          default: begin len = 768; ph = 401; end
        endcase
        return ((e + FLEN - ph) % FLEN) < len;
      end
      3: begin
        case (ch)
          0:       return e == 1500;
          1:       return (e >= 2971) && (e <= 3226);
          default: return (e == 4094) || ((e >= 5115) && (e <= 5118));
        endcase
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [2:0] e, input bit chk);
    exp_t x;
    x.r = r; x.g = g; x.b = b; x.e = e; x.chk = chk;
    sb.push_back(x);
  endtask

  task automatic do_reset(input int s);
    @(negedge clk);
    rst_n = 1'b0;
    scen  = s;
    repeat (3) @(negedge clk);
    check("reset_outputs", {5'd0, duty_r, duty_g, duty_b, valid, edge_seen}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_frames(input int n);
    while (cyc < n * FLEN + 4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  // Input driver: pin values for the next clock edge, set on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      pwm_r = ~is_low(scen, 0, cyc + 1);
      pwm_g = ~is_low(scen, 1, cyc + 1);
      pwm_b = ~is_low(scen, 2, cyc + 1);
    end
  end

  // Monitor: every valid pulse must land on a frame boundary and match the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_frames = 0;
      end else if (valid) begin
        mon_frames++;
        check("valid_timing", cyc, mon_frames * FLEN);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got a pulse at cyc %0d, expected none", cyc);
        end else begin
          x = sb.pop_front();
          if (x.chk)
            check("frame_result", {5'd0, duty_r, duty_g, duty_b, edge_seen},
                  {5'd0, x.r, x.g, x.b, x.e});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // All inputs idle high.
    do_reset(0);
    push(8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
    push(8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
    run_frames(2);

    // Loopback at 0x80/0x40/0xC0 with arbitrary phase; first frame includes sync start-up.
    do_reset(2);
    push(8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
    push(8'h80, 8'h40, 8'hC0, 3'b111, 1'b1);
    push(8'h80, 8'h40, 8'hC0, 3'b111, 1'b1);
    run_frames(3);

    // Mid-frame reset discards the partial frame; all inputs then held low.
    while (cyc < 3 * FLEN + 500) @(negedge clk);
    do_reset(1);
    // First frame: 1022 counted lows (sync start-up) and the start-up falling edge.
    push(8'hFF, 8'hFF, 8'hFF, 3'b111, 1'b1);
    // Full 1024 lows saturate to 0xFF, no edges.
    push(8'hFF, 8'hFF, 8'hFF, 3'b000, 1'b1);
    run_frames(2);

    // Glitches: R single cycle; G 256 lows split 100/156 across a wrap;
    // B single low on the frame-end sample, then 4 lows ending on frame end.
    do_reset(3);
    push(8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
    push(8'h00, 8'h00, 8'h00, 3'b100, 1'b1);
    push(8'h00, 8'h19, 8'h00, 3'b010, 1'b1);
    push(8'h00, 8'h27, 8'h00, 3'b011, 1'b1);
    push(8'h00, 8'h00, 8'h01, 3'b001, 1'b1);
    push(8'h00, 8'h00, 8'h00, 3'b001, 1'b1);
    run_frames(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
